// File: rtl/instr_mem_axi_rd_slave_if.sv
// axi_inf: AXI4 bundle shared by the instruction-cache master and the
// instruction-memory read responder.
//   ar / arready : read address channel (valid, addr, len, size, burst)
//   r  / rready  : read data channel (valid, data, resp, last)
//   awready, wready, b : write side (driven by the slave and tied off there)
interface axi_inf #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    typedef struct packed {
        logic                  valid;
        logic [ADDR_SIZE-1:0]  addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            resp;
    } b_t;

    ar_t  ar;
    logic arready;
    r_t   r;
    logic rready;
    logic awready;
    logic wready;
    b_t   b;

    modport slave  (input ar, input rready, output arready, output r,
                    output awready, output wready, output b);
    modport master (output ar, output rready, input arready, input r,
                    input awready, input wready, input b);
endinterface

// File: rtl/instr_mem_axi_rd_slave.sv
// instr_mem_axi_rd_slave: AXI4 read-only responder in front of a word-addressed
// synchronous instruction memory. One AR at a time, len+1 R beats, R-channel
// backpressure handled by stalling the memory enable.
//
// Optional feature macro: INSTR_MEM_AXI_WRAP_EN (WRAP bursts accepted; when
// undefined every WRAP request answers SLVERR on all beats).
//
// Ports:
//   i_clk       system clock
//   i_areset_n  synchronous active-low reset
//   axi         axi_inf.slave (read channels served, write side tied off)
//   o_mem_en    memory read enable; low holds the memory output register
//   o_mem_addr  memory word address
//   i_mem_data  memory read data, valid one cycle after an o_mem_en cycle
//   o_busy      high while a burst is outstanding
module instr_mem_axi_rd_slave #(
    parameter int                   ADDR_SIZE  = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   MEM_DEPTH  = 4096,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = '0
) (
    input  logic                         i_clk,
    input  logic                         i_areset_n,
    axi_inf.slave                        axi,
    output logic                         o_mem_en,
    output logic [$clog2(MEM_DEPTH)-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0]        i_mem_data,
    output logic                         o_busy
);
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int AW1 = ADDR_SIZE + 1;
    // One extra bit so the end-of-memory bound cannot overflow.
    localparam logic [ADDR_SIZE:0] MEM_END = {1'b0, BASE_ADDR} + AW1'(4 * MEM_DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_nx;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [7:0]           len_q;
    logic [1:0]           burst_q;
    logic                 err_q;
    logic [8:0]           issued;
    logic                 rvalid_q, rlast_q;
    logic                 arready, ar_hs, issue_burst, ar_err;

    function automatic logic [MAW-1:0] word_addr(input logic [ADDR_SIZE-1:0] a);
        logic [ADDR_SIZE-1:0] off;
        off = a - BASE_ADDR;
        return MAW'(off >> 2);
    endfunction

    // Address of the beat after 'a'. The wrap mask (len+1)*4-1 equals
    // {len,2'b11} for the legal wrap lengths; without WRAP support the
    // wrapped address is irrelevant because such bursts return zero data.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
        logic [ADDR_SIZE-1:0] inc, mask;
        inc  = a + ADDR_SIZE'(4);
        mask = ADDR_SIZE'({len, 2'b11});
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    assign arready     = (state == IDLE);
    assign ar_hs       = i_areset_n & axi.ar.valid & arready;
    // Stall the memory while a presented beat is not yet taken, so its data holds.
    assign issue_burst = (state == BURST) && (issued <= {1'b0, len_q}) &&
                         (!rvalid_q || axi.rready);

    assign o_mem_en   = i_areset_n & (ar_hs | issue_burst);
    assign o_mem_addr = ar_hs            ? word_addr(axi.ar.addr) :
                        (state == BURST) ? word_addr(addr_q) : '0;
    assign o_busy     = (state == BURST);

    always_comb begin
        ar_err = (axi.ar.size != 3'd2) ||
                 ({1'b0, axi.ar.addr} < {1'b0, BASE_ADDR}) ||
                 ({1'b0, axi.ar.addr} >= MEM_END);
        case (axi.ar.burst)
            BURST_FIXED, BURST_INCR: ;
`ifdef INSTR_MEM_AXI_WRAP_EN
            BURST_WRAP:
                if (!(axi.ar.len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (axi.ar.addr[1:0] != 2'b00))
                    ar_err = 1'b1;
`endif
            default: ar_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ar_hs) state_nx = BURST;
            BURST:   if (rvalid_q && axi.rready && rlast_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_areset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= BURST_FIXED;
            err_q    <= 1'b0;
            issued   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (ar_hs) begin
                // Beat 0 is issued on the handshake itself; addr_q tracks beat 1.
                addr_q  <= next_addr(axi.ar.addr, axi.ar.burst, axi.ar.len);
                len_q   <= axi.ar.len;
                burst_q <= axi.ar.burst;
                err_q   <= ar_err;
                issued  <= 9'd1;
            end else if (issue_burst) begin
                addr_q <= next_addr(addr_q, burst_q, len_q);
                issued <= issued + 9'd1;
            end

            if (ar_hs || issue_burst) begin
                rvalid_q <= 1'b1;
                rlast_q  <= ar_hs ? (axi.ar.len == 8'd0) : (issued == {1'b0, len_q});
            end else if (axi.rready) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        axi.r       = '0;
        axi.r.valid = rvalid_q;
        axi.r.last  = rlast_q;
        axi.r.resp  = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
        axi.r.data  = (rvalid_q && !err_q) ? i_mem_data : '0;
        axi.b       = '0;
    end

    assign axi.arready = arready;
    assign axi.awready = 1'b0;
    assign axi.wready  = 1'b0;
endmodule

// File: tb/tb_instr_mem_axi_rd_slave.sv
// Scoreboard bench for instr_mem_axi_rd_slave: stimulus pushes expected beats,
// a negedge monitor pops/compares accepted beats and checks held beats.
module tb_instr_mem_axi_rd_slave;
    localparam int AW = 32, DW = 32, DEPTH = 4096, MAW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_inf #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) axi ();
    logic           mem_en;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_data = '0;
    logic           busy;

    instr_mem_axi_rd_slave #(.ADDR_SIZE(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_areset_n(rst_n), .axi(axi),
        .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_data(mem_data), .o_busy(busy)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

    function automatic logic [31:0] mv(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } beat_t;
    beat_t exp_q[$];
    int checks = 0, passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] resp, input logic last);
        beat_t b;
        b.data = d; b.resp = resp; b.last = last;
        exp_q.push_back(b);
    endtask

    // Monitor: accepted beats are popped; a held beat must match the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && axi.r.valid) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
            else begin
                e = exp_q[0];
                chk(axi.rready ? "beat" : "stall_hold",
                    {axi.r.data, axi.r.resp, axi.r.last}, {e.data, e.resp, e.last});
                if (axi.rready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        while (!axi.arready && n < 100) begin @(posedge clk); #1; n++; end
        if (!axi.arready) chk("arready_timeout", 64'd0, 64'd1);
        axi.ar.addr = a; axi.ar.len = len; axi.ar.size = size; axi.ar.burst = burst;
        axi.ar.valid = 1'b1;
        @(posedge clk); #1 axi.ar.valid = 1'b0;
        @(negedge clk);
        chk("first_beat_latency", 64'(axi.r.valid), 64'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
        chk({name, "_done"}, 64'(exp_q.size() == 0 && !busy), 64'd1);
        chk({name, "_arready"}, 64'(axi.arready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = mv(i);
        axi.ar = '0;
        axi.rready = 1'b0;

        // Reset values after the first edge with reset low.
        @(posedge clk); #1;
        chk("rst_rvalid", 64'(axi.r.valid), 64'd0);
        chk("rst_rlast",  64'(axi.r.last),  64'd0);
        chk("rst_rresp",  64'(axi.r.resp),  64'd0);
        chk("rst_rdata",  64'(axi.r.data),  64'd0);
        chk("rst_arready", 64'(axi.arready), 64'd1);
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst_mem_en", 64'(mem_en),   64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        axi.rready = 1'b1;
        @(posedge clk); #1;

        // INCR 0x40 len 3: words 16..19.
        for (int i = 0; i < 4; i++) push(mv(16 + i), 2'd0, i == 3);
        send_ar(32'h40, 8'd3, 3'd2, 2'd1);
        wait_done("incr");

        // Backpressure: rready low for three cycles while beat B is presented.
        for (int i = 0; i < 4; i++) push(mv(16 + i), 2'd0, i == 3);
        send_ar(32'h40, 8'd3, 3'd2, 2'd1);
        @(posedge clk); #1 axi.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 axi.rready = 1'b1;
        wait_done("backpressure");

        // Bad size: two SLVERR beats with zero data.
        push(32'h0, 2'd2, 1'b0); push(32'h0, 2'd2, 1'b1);
        send_ar(32'h40, 8'd1, 3'd1, 2'd1);
        wait_done("err_size");

        // Address at end of memory.
        push(32'h0, 2'd2, 1'b0); push(32'h0, 2'd2, 1'b1);
        send_ar(32'h4000, 8'd1, 3'd2, 2'd1);
        wait_done("err_range");

        // FIXED burst repeats word 17.
        for (int i = 0; i < 3; i++) push(mv(17), 2'd0, i == 2);
        send_ar(32'h44, 8'd2, 3'd2, 2'd0);
        wait_done("fixed");

        // INCR running off the top of memory wraps to word 0.
        push(mv(4095), 2'd0, 1'b0); push(mv(0), 2'd0, 1'b1);
        send_ar(32'h3FFC, 8'd1, 3'd2, 2'd1);
        wait_done("top_wrap");

        // WRAP 0x48 len 3.
`ifdef INSTR_MEM_AXI_WRAP_EN
        push(mv(18), 2'd0, 1'b0); push(mv(19), 2'd0, 1'b0);
        push(mv(16), 2'd0, 1'b0); push(mv(17), 2'd0, 1'b1);
`else
        for (int i = 0; i < 4; i++) push(32'h0, 2'd2, i == 3);
`endif
        send_ar(32'h48, 8'd3, 3'd2, 2'd2);
        wait_done("wrap");

        // Reset in the middle of an 8-beat burst, after two beats are taken.
        push(mv(0), 2'd0, 1'b0); push(mv(1), 2'd0, 1'b0);
        send_ar(32'h0, 8'd7, 3'd2, 2'd1);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rvalid",  64'(axi.r.valid), 64'd0);
        chk("midrst_arready", 64'(axi.arready), 64'd1);
        chk("midrst_busy",    64'(busy),        64'd0);
        chk("midrst_queue",   64'(exp_q.size()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beat after reset.
        push(mv(17), 2'd0, 1'b1);
        send_ar(32'h44, 8'd0, 3'd2, 2'd1);
        wait_done("single");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
